// File: rtl/histogram_pkg.sv
// Shared definitions for the parametric histogram:
//   - controller state encoding (histState_t)
//   - width helpers used to derive the channel index width
//   - widths of the event and drop counters
package histogram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } histState_t;

    localparam int TOTAL_WIDTH = 32;
    localparam int DROP_WIDTH  = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // A single channel still needs a one-bit channel port.
    function automatic int chWidth(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

endpackage

// File: rtl/histogram_bram.sv
// Dual-port count RAM with one-cycle registered reads.
//   clk            : single clock for both ports
//   aWriteEnable   : port A write strobe
//   aWriteAddress  : port A write address (increment write-back or clear sweep)
//   aWriteData     : port A write data
//   aReadAddress   : port A read address (increment fetch)
//   aReadData      : port A registered read data
//   bWriteEnable   : port B write strobe
//   bWriteAddress  : port B write address
//   bWriteData     : port B write data
//   bReadAddress   : port B read address
//   bReadData      : port B registered read data
// Reads are read-first: a read and a write to the same address at the
// same edge return the previous contents.
module histogram_bram #(
    parameter int ADDR_WIDTH  = 11,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   aWriteEnable,
    input  logic [ADDR_WIDTH-1:0]  aWriteAddress,
    input  logic [COUNT_WIDTH-1:0] aWriteData,
    input  logic [ADDR_WIDTH-1:0]  aReadAddress,
    output logic [COUNT_WIDTH-1:0] aReadData,
    input  logic                   bWriteEnable,
    input  logic [ADDR_WIDTH-1:0]  bWriteAddress,
    input  logic [COUNT_WIDTH-1:0] bWriteData,
    input  logic [ADDR_WIDTH-1:0]  bReadAddress,
    output logic [COUNT_WIDTH-1:0] bReadData
);

    logic [COUNT_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (aWriteEnable) mem[aWriteAddress] <= aWriteData;
        if (bWriteEnable) mem[bWriteAddress] <= bWriteData;
        aReadData <= mem[aReadAddress];
        bReadData <= mem[bReadAddress];
    end

endmodule

// File: rtl/parametric_histogram.sv
// Multi-channel event histogram with saturating bin counters.
//   clk                  : clock
//   reset                : synchronous, active-low reset
//   valueValid           : one event per high cycle
//   valueChannel         : event channel
//   radiationValue       : event bin
//   clearStart           : pulse requesting a full clear
//   busy                 : high while draining or clearing
//   histogramReadAddress : readback address {channel, bin}
//   histogramReadValue   : count at the readback address (two-edge latency)
//   totalEvents          : accepted events since last clear (wraps)
//   droppedEvents        : rejected events since reset (saturates)
//   saturatedFlag        : sticky, a bin reached its maximum count
module parametric_histogram
    import histogram_pkg::*;
#(
    parameter  int BIN_WIDTH   = 10,
    parameter  int COUNT_WIDTH = 16,
    parameter  int CHANNELS    = 1,
    localparam int CH_WIDTH    = chWidth(CHANNELS),
    localparam int ADDR_WIDTH  = CH_WIDTH + BIN_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valueValid,
    input  logic [CH_WIDTH-1:0]    valueChannel,
    input  logic [BIN_WIDTH-1:0]   radiationValue,
    input  logic                   clearStart,
    output logic                   busy,
    input  logic [ADDR_WIDTH-1:0]  histogramReadAddress,
    output logic [COUNT_WIDTH-1:0] histogramReadValue,
    output logic [TOTAL_WIDTH-1:0] totalEvents,
    output logic [DROP_WIDTH-1:0]  droppedEvents,
    output logic                   saturatedFlag
);

    localparam int                     DEPTH     = CHANNELS * (2 ** BIN_WIDTH);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CH_WIDTH:0]      CH_LIMIT  = (CH_WIDTH + 1)'(CHANNELS);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [DROP_WIDTH-1:0]  DROP_MAX  = '1;

    function automatic logic [COUNT_WIDTH-1:0] satIncCount(input logic [COUNT_WIDTH-1:0] v);
        return (v == COUNT_MAX) ? v : v + COUNT_WIDTH'(1);
    endfunction

    function automatic logic [DROP_WIDTH-1:0] satIncDrop(input logic [DROP_WIDTH-1:0] v);
        return (v == DROP_MAX) ? v : v + DROP_WIDTH'(1);
    endfunction

    histState_t             state, nextState;
    logic                   autoClear;
    logic                   clearWrite;
    logic [ADDR_WIDTH-1:0]  clrAddr;
    logic                   accept, enterDrain, pipeEmpty;

    logic                   vld_p1, vld_p2, vld_p3, vld_p4;
    logic [ADDR_WIDTH-1:0]  addr_p1, addr_p2, addr_p3, addr_p4;
    logic [COUNT_WIDTH-1:0] cnt_p3, cnt_p4;
    logic [COUNT_WIDTH-1:0] oldCount;
    logic [ADDR_WIDTH-1:0]  readAddr_p1;

    logic                   ramWriteEnable;
    logic [ADDR_WIDTH-1:0]  ramWriteAddress;
    logic [COUNT_WIDTH-1:0] ramWriteData;
    logic [COUNT_WIDTH-1:0] ramReadData;
    logic [COUNT_WIDTH-1:0] ramReadbackData;

    assign accept     = valueValid && !busy && ({1'b0, valueChannel} < CH_LIMIT);
    assign enterDrain = (state == IDLE) && (clearStart || autoClear);
    assign pipeEmpty  = !(vld_p1 || vld_p2 || vld_p3);

    // State register; autoClear forces one clear sweep after every reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            autoClear <= 1'b1;
        end else begin
            state <= nextState;
            if (state == IDLE) autoClear <= 1'b0;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (clearStart || autoClear) nextState = DRAIN;
            DRAIN:   if (pipeEmpty) nextState = CLEAR;
            CLEAR:   if (clrAddr == LAST_ADDR) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        clearWrite = (state == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clrAddr <= '0;
        end else if (state == DRAIN) begin
            clrAddr <= '0;
        end else if (state == CLEAR) begin
            clrAddr <= clrAddr + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            vld_p4 <= 1'b0;
        end else begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            vld_p4 <= vld_p3;
        end
    end

    // The RAM read of addr_p2 was captured at the same edge that committed
    // the p4 write, and read-first hides that write; the p3 write is still
    // pending. Both are checked, youngest first.
    always_comb begin
        if (vld_p3 && (addr_p3 == addr_p2)) begin
            oldCount = cnt_p3;
        end else if (vld_p4 && (addr_p4 == addr_p2)) begin
            oldCount = cnt_p4;
        end else begin
            oldCount = ramReadData;
        end
    end

    always_ff @(posedge clk) begin
        // S1: event address registered, RAM fetch issued
        addr_p1 <= {valueChannel, radiationValue};
        // S2: RAM data for addr_p1 returns on ramReadData
        addr_p2 <= addr_p1;
        // S3: incremented count registered for write-back
        addr_p3 <= addr_p2;
        cnt_p3  <= satIncCount(oldCount);
        // S4: write committed to RAM, kept for forwarding
        addr_p4 <= addr_p3;
        cnt_p4  <= cnt_p3;
        readAddr_p1 <= histogramReadAddress;
    end

    // Clear sweep and increment write-back share port A; they never overlap
    // because the sweep starts only once the pipeline has drained.
    always_comb begin
        ramWriteEnable  = vld_p3 || clearWrite;
        ramWriteAddress = clearWrite ? clrAddr : addr_p3;
        ramWriteData    = clearWrite ? '0 : cnt_p3;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            totalEvents   <= '0;
            saturatedFlag <= 1'b0;
            droppedEvents <= '0;
        end else begin
            // Held at zero while busy so an event accepted alongside
            // clearStart, whose bin is then wiped, is not counted.
            if (enterDrain || busy) begin
                totalEvents   <= '0;
                saturatedFlag <= 1'b0;
            end else begin
                totalEvents <= totalEvents + TOTAL_WIDTH'(vld_p1);
                if (vld_p3 && (cnt_p3 == COUNT_MAX)) saturatedFlag <= 1'b1;
            end
            if (valueValid && !accept) droppedEvents <= satIncDrop(droppedEvents);
        end
    end

    assign histogramReadValue = reset ? ramReadbackData : '0;

    histogram_bram #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_bram (
        .clk           (clk),
        .aWriteEnable  (ramWriteEnable),
        .aWriteAddress (ramWriteAddress),
        .aWriteData    (ramWriteData),
        .aReadAddress  (addr_p1),
        .aReadData     (ramReadData),
        .bWriteEnable  (1'b0),
        .bWriteAddress (readAddr_p1),
        .bWriteData    ('0),
        .bReadAddress  (readAddr_p1),
        .bReadData     (ramReadbackData)
    );

endmodule

// File: doc/parametric_histogram.md
# parametric_histogram

Parametrised, multi-channel successor to the single-channel radiation histogram. It accumulates per-channel, per-bin event counts in one true-dual-port block RAM. Port A runs a hazard-free read-modify-write pipeline that accepts one event per cycle. Port B serves AXI-register readback. The block sits between the radiation processor and the RadiationReceiver AXI-Lite slave, and adds saturation, clear sweep, drop accounting and automatic post-reset clear.

## Interface
- BIN_WIDTH, default 10: bin index width; bins per channel = 2^BIN_WIDTH.
- COUNT_WIDTH, default 16: width of each bin counter.
- CHANNELS, default 1: number of histogram channels.
- CH_WIDTH, derived as max(1, clog2(CHANNELS)): channel index width. ADDR_WIDTH = CH_WIDTH + BIN_WIDTH. DEPTH = CHANNELS * 2^BIN_WIDTH.
- clk  in  1  single clock for all logic and both RAM ports.
- reset  in  1  synchronous, active-low reset.
- valueValid  in  1  per-cycle event strobe; each high cycle is one event (not edge-detected).
- valueChannel  in  CH_WIDTH  channel of the event.
- radiationValue  in  BIN_WIDTH  bin of the event.
- clearStart  in  1  single-cycle pulse requesting a full clear.
- busy  out  1  high while draining or clearing.
- histogramReadAddress  in  ADDR_WIDTH  readback address {channel, bin}.
- histogramReadValue  out  COUNT_WIDTH  count at histogramReadAddress.
- totalEvents  out  32  accepted events since the last clear; wraps.
- droppedEvents  out  16  rejected events since reset; saturates at 0xFFFF.
- saturatedFlag  out  1  sticky; set when any bin reaches its maximum count.

## Operation
- Bin address is {valueChannel, radiationValue}.
- An event is accepted when valueValid=1, busy=0 and valueChannel<CHANNELS. Otherwise it is dropped, and droppedEvents increments if valueValid=1.
- Port A pipeline:
  - S1: register the address.
  - S2: RAM data returns.
  - S3: write back the new count.
- Increment rules:
  - New count = old+1, held at 2^COUNT_WIDTH−1; saturatedFlag sets when that maximum is written.
  - Old value is forwarded from the youngest in-flight S3 write to the same address, else taken from RAM. Back-to-back events to one bin must never lose counts.
- States (enum in package):
  - IDLE, DRAIN, CLEAR.
  - IDLE→DRAIN on clearStart, or on the first cycle after reset release.
  - DRAIN→CLEAR once the pipeline is empty (at most 3 cycles).
  - CLEAR writes 0 to address 0..DEPTH−1, one address per cycle, via port A.
  - CLEAR→IDLE after writing address DEPTH−1.
- busy=1 in DRAIN and CLEAR. clearStart while busy is ignored.
- At entry to DRAIN: totalEvents←0 and saturatedFlag←0. droppedEvents is not cleared.
- Port B is read-only: write enable is tied 0 and the address is registered from histogramReadAddress each cycle.
- A readback during CLEAR returns either the old value or 0.

## Timing
- While reset=0: all outputs are 0 and the pipeline is empty. RAM contents are undefined until the automatic clear completes.
- Automatic clear: busy rises on the first edge after reset release and falls DEPTH+≤4 cycles later.
- Increment latency: an event sampled at edge t commits to RAM at edge t+3. totalEvents updates at edge t+1.
- Readback latency: histogramReadValue reflects the address presented at edge t from edge t+2.
- Throughput: one event per cycle, sustained, with no backpressure.
- Simultaneous valueValid and clearStart in IDLE: the event is accepted, then the drain begins.
- Reset asserted mid-clear: the clear aborts, and the automatic clear restarts from address 0 after release.
- An event with channel≥CHANNELS is always dropped, even when the RAM has spare depth.

## Structure
- Package histogram_pkg holds:
  - the state enum;
  - width-derivation helpers (clog2, CH_WIDTH);
  - the totalEvents and droppedEvents width constants.
- Sub-module histogram_bram: parametrised (ADDR_WIDTH, COUNT_WIDTH) true-dual-port RAM, one-cycle registered read, maps onto the vendor BRAM.
- The top level holds the pipeline, the forwarding compare, the FSM and the counters.

## Test plan
- Reset then idle: busy high for DEPTH+≤4 cycles with BIN_WIDTH=4, CHANNELS=2 (32 addresses); all 32 readbacks return 0.
- Bin 5, channel 1, strobed 10 consecutive cycles → address 21 reads 10 and totalEvents=10 (exercises forwarding).
- Alternating bins 3,4,3,4 for 8 cycles → each reads 4, with no lost counts.
- COUNT_WIDTH=4, 20 events to bin 0 → reads 15 and saturatedFlag=1.
- clearStart with events running → events during busy add to droppedEvents; afterwards all bins read 0 and totalEvents=0.
- CHANNELS=3, event with valueChannel=3 → droppedEvents=1 and no bin changes.
